if_pix_feeder: RTL
==================

IF_PIX_FEEDER -- requirements
Module: if_pix_feeder

Interface
REQ-001 Parameter DWd, default 16, pixel data width.
REQ-002 Parameter ConfDWd, default 4, width of row-length and row-count fields.
REQ-003 Parameter PConfDWd, default 3, width of the channel-count field.
REQ-004 Parameter BufAddrWd, default 10, IF buffer read address width.
REQ-005 Ports, one per line; the design SHALL have one clock, and reset SHALL be asynchronous, active-low:
  i_clk  in  1  clock, rising edge
  i_rstn  in  1  asynchronous active-low reset
  i_cont_IFLen  in  ConfDWd  pixels per row
  i_cont_Pch  in  PConfDWd  channels per pixel
  i_cont_rows  in  ConfDWd  rows per job
  i_cont_base  in  BufAddrWd  job start address
  i_cont_start  in  1  job start pulse
  i_cont_stall  in  1  suppress new buffer reads
  o_cont_busy  out  1  job in progress
  o_cont_nxtRow  out  1  row-complete pulse
  o_cont_done  out  1  job-complete pulse
  o_buf_ren  out  1  buffer read enable
  o_buf_raddr  out  BufAddrWd  buffer read address
  i_buf_rdata  in  DWd  read data, valid one cycle after o_buf_ren
  o_ipix_wdata  out  DWd  pixel to IFPAD
  o_ipix_valid  out  1  pixel valid
  i_ipix_ready  in  1  IFPAD accepts pixel

Function
REQ-006 A start pulse in IDLE SHALL latch IFLen, Pch, rows and base; o_cont_busy SHALL rise the next cycle.
REQ-007 A start pulse while busy SHALL be ignored.
REQ-008 If IFLen, Pch or rows is zero at start, the block SHALL emit no pixels, pulse o_cont_done one cycle after start, and stay IDLE.
REQ-009 FSM states SHALL be IDLE, FETCH and DRAIN.
REQ-010 Transitions: IDLE->FETCH on a valid start; FETCH->DRAIN after the last read issues; DRAIN->IDLE when the last pixel is accepted.
REQ-011 Pixel order SHALL be channel fastest, then column, then row.
REQ-012 Total pixels per job SHALL be IFLen*Pch*rows.
REQ-013 Read address SHALL be base plus the linear pixel index, modulo 2^BufAddrWd (wrap-around).
REQ-014 Returned data SHALL enter a 2-entry output FIFO; o_ipix_valid SHALL equal FIFO non-empty; o_ipix_wdata SHALL be the FIFO head.
REQ-015 A pixel SHALL transfer when o_ipix_valid && i_ipix_ready.
REQ-016 o_ipix_valid and o_ipix_wdata SHALL hold stable while ready is low.
REQ-017 A read SHALL issue in FETCH only when stall is low and (occupancy + in-flight - pop_this_cycle) < 2; the FIFO SHALL never overflow.
REQ-018 With ready high and stall low, throughput SHALL be 1 pixel/cycle.
REQ-019 First o_ipix_valid SHALL appear no earlier than 2 cycles after start.
REQ-020 Stall SHALL block reads only; FIFO draining SHALL continue during stall.
REQ-021 o_cont_nxtRow SHALL pulse for 1 cycle when the last pixel of each row (last row included) is accepted.
REQ-022 o_cont_done SHALL pulse for 1 cycle in the same cycle as the final acceptance; busy SHALL fall the next cycle.
REQ-023 o_buf_ren SHALL be 0 outside FETCH.

Reset
REQ-024 On i_rstn low, all outputs SHALL be 0, FSM SHALL be IDLE, and FIFO, counters and in-flight flag SHALL clear immediately.
REQ-025 A reset mid-job SHALL abandon the job; read data returning after reset release SHALL be discarded.

Structure
REQ-026 The FSM state enum and default widths SHALL live in the shared IF typedef package.
REQ-027 The 2-entry FIFO SHALL be a sub-module named pix_skid_fifo.

Verification
REQ-028 IFLen=3, Pch=2, rows=2, base=0x010, ready=1, no stall -> 12 pixels at addresses 0x010..0x01B, one per cycle; nxtRow after pixels 6 and 12; done with pixel 12.
REQ-029 Same job, ready toggling 1/0 -> identical data order; data held while ready=0; no FIFO overflow.
REQ-030 base=0x3FE, 4 pixels -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-031 Stall high for 5 cycles mid-job -> no o_buf_ren during stall; FIFO drains; pixel count remains exact.
REQ-032 Pch=0 start -> done one cycle later; no valid; busy stays 0.
REQ-033 Reset asserted after pixel 3 -> outputs 0 immediately; a new job after reset produces correct data from its own base.

Source files
------------

// File: rtl/if_pix_feeder_pkg.sv
// Shared types and default widths for the IF pixel feeder.
package if_pix_feeder_pkg;

    localparam int DEF_DWD         = 16;
    localparam int DEF_CONF_DWD    = 4;
    localparam int DEF_PCONF_DWD   = 3;
    localparam int DEF_BUF_ADDR_WD = 10;

    // Read-side sequencing: IDLE waits for a job, FETCH issues buffer reads,
    // DRAIN waits for the last pixel to leave the output FIFO.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } feed_state_t;

endpackage

// File: rtl/if_pix_feeder_skid_fifo.sv
// Two-entry output FIFO: head is always the oldest pixel and stays put until popped.
module pix_skid_fifo #(
    parameter int DWd = 16
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_push,
    input  logic [DWd-1:0] i_din,
    input  logic           i_pop,
    output logic [DWd-1:0] o_head,
    output logic [1:0]     o_count
);

    logic [DWd-1:0] head_reg;
    logic [DWd-1:0] tail_reg;
    logic [1:0]     count_reg;
    logic           do_push;
    logic           do_pop;

    // A pop on an empty FIFO or a push into a full one without a pop is dropped.
    assign do_pop  = i_pop && (count_reg != 2'd0);
    assign do_push = i_push && ((count_reg != 2'd2) || do_pop);

    // Head/tail shuffle for the four push/pop combinations.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= 2'd0;
        end else if (do_push && do_pop) begin
            if (count_reg == 2'd1) begin
                head_reg <= i_din;
            end else begin
                head_reg <= tail_reg;
                tail_reg <= i_din;
            end
        end else if (do_push) begin
            if (count_reg == 2'd0) begin
                head_reg <= i_din;
            end else begin
                tail_reg <= i_din;
            end
            count_reg <= count_reg + 2'd1;
        end else if (do_pop) begin
            head_reg  <= tail_reg;
            count_reg <= count_reg - 2'd1;
        end
    end

    assign o_head  = head_reg;
    assign o_count = count_reg;

endmodule

// File: rtl/if_pix_feeder.sv
// Reads a job of IFLen*Pch*rows pixels from the IF buffer and streams them
// to IFPAD through a two-entry FIFO with valid/ready handshake.
module if_pix_feeder
    import if_pix_feeder_pkg::*;
#(
    parameter int DWd       = DEF_DWD,
    parameter int ConfDWd   = DEF_CONF_DWD,
    parameter int PConfDWd  = DEF_PCONF_DWD,
    parameter int BufAddrWd = DEF_BUF_ADDR_WD
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [ConfDWd-1:0]   i_cont_IFLen,
    input  logic [PConfDWd-1:0]  i_cont_Pch,
    input  logic [ConfDWd-1:0]   i_cont_rows,
    input  logic [BufAddrWd-1:0] i_cont_base,
    input  logic                 i_cont_start,
    input  logic                 i_cont_stall,
    output logic                 o_cont_busy,
    output logic                 o_cont_nxtRow,
    output logic                 o_cont_done,
    output logic                 o_buf_ren,
    output logic [BufAddrWd-1:0] o_buf_raddr,
    input  logic [DWd-1:0]       i_buf_rdata,
    output logic [DWd-1:0]       o_ipix_wdata,
    output logic                 o_ipix_valid,
    input  logic                 i_ipix_ready
);

    localparam logic [ConfDWd-1:0]   C_ONE = ConfDWd'(1);
    localparam logic [PConfDWd-1:0]  P_ONE = PConfDWd'(1);
    localparam logic [BufAddrWd-1:0] A_ONE = BufAddrWd'(1);

    feed_state_t          state;
    logic [ConfDWd-1:0]   len_reg, rows_reg;
    logic [PConfDWd-1:0]  pch_reg;
    logic [BufAddrWd-1:0] addr_reg;
    logic [PConfDWd-1:0]  rd_ch, out_ch;
    logic [ConfDWd-1:0]   rd_col, rd_row, out_col, out_row;
    logic                 inflight_reg;
    logic                 zero_done_reg;

    logic [ConfDWd-1:0]   len_max, rows_max;
    logic [PConfDWd-1:0]  pch_max;
    logic [1:0]           fifo_count;
    logic [DWd-1:0]       fifo_head;
    logic                 pix_valid, pop, rd_issue, rd_last, out_row_end, out_last;
    logic [2:0]           occ_sum;

    assign len_max  = len_reg - C_ONE;
    assign rows_max = rows_reg - C_ONE;
    assign pch_max  = pch_reg - P_ONE;

    assign pix_valid = (fifo_count != 2'd0);
    assign pop       = pix_valid && i_ipix_ready;

    // Slots already promised (stored + returning) minus the one leaving now.
    assign occ_sum  = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
    assign rd_issue = (state == FETCH) && !i_cont_stall && (occ_sum < 3'd2);
    assign rd_last  = (rd_ch == pch_max) && (rd_col == len_max) && (rd_row == rows_max);

    assign out_row_end = (out_ch == pch_max) && (out_col == len_max);
    assign out_last    = out_row_end && (out_row == rows_max);

    // Job sequencing, read-side and accept-side position counters.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state         <= IDLE;
            len_reg       <= '0;
            pch_reg       <= '0;
            rows_reg      <= '0;
            addr_reg      <= '0;
            rd_ch         <= '0;
            rd_col        <= '0;
            rd_row        <= '0;
            out_ch        <= '0;
            out_col       <= '0;
            out_row       <= '0;
            inflight_reg  <= 1'b0;
            zero_done_reg <= 1'b0;
        end else begin
            zero_done_reg <= 1'b0;
            inflight_reg  <= rd_issue;
            case (state)
                IDLE: begin
                    if (i_cont_start) begin
                        if ((i_cont_IFLen == '0) || (i_cont_Pch == '0) || (i_cont_rows == '0)) begin
                            zero_done_reg <= 1'b1;
                        end else begin
                            len_reg  <= i_cont_IFLen;
                            pch_reg  <= i_cont_Pch;
                            rows_reg <= i_cont_rows;
                            addr_reg <= i_cont_base;
                            rd_ch    <= '0;
                            rd_col   <= '0;
                            rd_row   <= '0;
                            state    <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (rd_issue) begin
                        addr_reg <= addr_reg + A_ONE;
                        if (rd_ch == pch_max) begin
                            rd_ch <= '0;
                            if (rd_col == len_max) begin
                                rd_col <= '0;
                                rd_row <= rd_row + C_ONE;
                            end else begin
                                rd_col <= rd_col + C_ONE;
                            end
                        end else begin
                            rd_ch <= rd_ch + P_ONE;
                        end
                        if (rd_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (pop) begin
                if (out_row_end) begin
                    out_ch  <= '0;
                    out_col <= '0;
                    out_row <= out_last ? '0 : (out_row + C_ONE);
                end else if (out_ch == pch_max) begin
                    out_ch  <= '0;
                    out_col <= out_col + C_ONE;
                end else begin
                    out_ch <= out_ch + P_ONE;
                end
            end
        end
    end

    pix_skid_fifo #(
        .DWd(DWd)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_push (inflight_reg),
        .i_din  (i_buf_rdata),
        .i_pop  (pop),
        .o_head (fifo_head),
        .o_count(fifo_count)
    );

    assign o_cont_busy   = (state != IDLE);
    assign o_cont_nxtRow = pop && out_row_end;
    assign o_cont_done   = zero_done_reg || (pop && out_last);
    assign o_buf_ren     = rd_issue;
    assign o_buf_raddr   = addr_reg;
    assign o_ipix_valid  = pix_valid;
    assign o_ipix_wdata  = fifo_head;

endmodule
